// File: rtl/lc3b_types.sv
// Shared LC-3b decode types: opcodes, immediate selects, the control word
// and the default datapath sizing used by the decode stage.
package lc3b_types;

  localparam int XLEN_DEFAULT  = 16;
  localparam int NREGS_DEFAULT = 8;

  typedef enum logic [3:0] {
    OP_BR  = 4'h0, OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB  = 4'h3,
    OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR  = 4'h7,
    OP_RTI = 4'h8, OP_XOR = 4'h9, OP_LDI = 4'hA, OP_STI  = 4'hB,
    OP_JMP = 4'hC, OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF
  } opcode_t;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_ADJ6, IMM_SEXT5, IMM_SEXT6,
    IMM_ZEXT4, IMM_ADJ9, IMM_ADJ11, IMM_TRAP8
  } imm_sel_t;

  typedef struct packed {
    opcode_t  opcode;
    imm_sel_t imm_sel;
    logic     use_imm;
    logic     sr1_used;
    logic     sr2_used;
    logic     sr2_is_dest;  // stores read their data register from [11:9]
    logic     reg_write;
    logic     dest_link;    // JSR/TRAP write the link register
    logic     mem_read;
    logic     mem_write;
    logic     branch;
  } lc3b_control_word;

endpackage

// File: rtl/control_rom.sv
// Opcode-to-control-word table for the LC-3b decode stage.
module control_rom
  import lc3b_types::*;
(
  input  logic [3:0]       op,
  input  logic             long_form,
  input  logic             imm_form,
  output lc3b_control_word ctrl
);

  // NOTE: combinational logic uses blocking assignments and sets a default
  // for every output first, so no path can infer a latch.
  always_comb begin
    ctrl        = '0;
    ctrl.opcode = opcode_t'(op);
    case (ctrl.opcode)
      OP_BR: begin
        ctrl.imm_sel = IMM_ADJ9;
        ctrl.branch  = 1'b1;
      end
      OP_ADD, OP_AND, OP_XOR: begin
        ctrl.sr1_used  = 1'b1;
        ctrl.sr2_used  = !imm_form;
        ctrl.use_imm   = imm_form;
        ctrl.imm_sel   = IMM_SEXT5;
        ctrl.reg_write = 1'b1;
      end
      OP_SHF: begin
        ctrl.sr1_used  = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.imm_sel   = IMM_ZEXT4;
        ctrl.reg_write = 1'b1;
      end
      OP_LDB, OP_LDR, OP_LDI: begin
        ctrl.sr1_used  = 1'b1;
        ctrl.use_imm   = 1'b1;
        ctrl.imm_sel   = (ctrl.opcode == OP_LDB) ? IMM_SEXT6 : IMM_ADJ6;
        ctrl.reg_write = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      OP_STB, OP_STR, OP_STI: begin
        ctrl.sr1_used    = 1'b1;
        ctrl.sr2_used    = 1'b1;
        ctrl.sr2_is_dest = 1'b1;
        ctrl.use_imm     = 1'b1;
        ctrl.imm_sel     = (ctrl.opcode == OP_STB) ? IMM_SEXT6 : IMM_ADJ6;
        ctrl.mem_write   = 1'b1;
      end
      OP_JSR: begin
        ctrl.reg_write = 1'b1;
        ctrl.dest_link = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.sr1_used  = !long_form;
        ctrl.imm_sel   = long_form ? IMM_ADJ11 : IMM_NONE;
      end
      OP_JMP: begin
        ctrl.sr1_used = 1'b1;
        ctrl.branch   = 1'b1;
      end
      OP_LEA: begin
        ctrl.use_imm   = 1'b1;
        ctrl.imm_sel   = IMM_ADJ9;
        ctrl.reg_write = 1'b1;
      end
      OP_TRAP: begin
        ctrl.imm_sel   = IMM_TRAP8;
        ctrl.reg_write = 1'b1;
        ctrl.dest_link = 1'b1;
        ctrl.branch    = 1'b1;
        ctrl.mem_read  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_scoreboard.sv
// Per-register pending-write counters and the decode hazard check.
// DECODE_WB_BYPASS_EN lets a count==1 source resolve by a same-cycle write-back.
module decode_scoreboard #(
  parameter  int NREGS    = 8,
  parameter  int MAX_PEND = 3,
  localparam int RW       = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc_en,
  input  logic [RW-1:0] inc_idx,
  input  logic          wb_load,
  input  logic [RW-1:0] wb_dest,
  input  logic          flush_dec,
  input  logic [RW-1:0] flush_idx,
  input  logic          src1_used,
  input  logic [RW-1:0] src1_idx,
  input  logic          src2_used,
  input  logic [RW-1:0] src2_idx,
  input  logic          dest_used,
  input  logic [RW-1:0] dest_idx,
  output logic          hazard
);

  localparam int CW = $clog2(MAX_PEND + 1);

  logic [CW-1:0] count      [NREGS];
  logic [CW-1:0] count_next [NREGS];

  // Increments and both decrement sources are summed first, then clamped,
  // so a flush and a write-back on the same register stack and stop at zero.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      int n;
      n = int'(count[i]);
      if (inc_en    && inc_idx   == RW'(i)) n = n + 1;
      if (wb_load   && wb_dest   == RW'(i)) n = n - 1;
      if (flush_dec && flush_idx == RW'(i)) n = n - 1;
      if (n < 0)        n = 0;
      if (n > MAX_PEND) n = MAX_PEND;
      count_next[i] = CW'(n);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) count[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) count[i] <= count_next[i];
    end
  end

  function automatic logic src_blocked(input logic used, input logic [RW-1:0] idx);
    logic bypass;
`ifdef DECODE_WB_BYPASS_EN
    bypass = (count[idx] == CW'(1)) && wb_load && (wb_dest == idx);
`else
    bypass = 1'b0;
`endif
    return used && (count[idx] != '0) && !bypass;
  endfunction

  always_comb begin
    hazard = src_blocked(src1_used, src1_idx) ||
             src_blocked(src2_used, src2_idx) ||
             (dest_used && (count[dest_idx] == CW'(MAX_PEND)));
  end

endmodule

// File: rtl/decode_stage.sv
// LC-3b decode stage: register read, immediate select, scoreboard stall and
// one output register. DECODE_WB_BYPASS_EN forwards same-cycle write-back data.
module decode_stage
  import lc3b_types::*;
#(
  parameter  int XLEN     = XLEN_DEFAULT,
  parameter  int NREGS    = NREGS_DEFAULT,
  parameter  int MAX_PEND = 3,
  localparam int RW       = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output lc3b_control_word out_ctrl,
  output logic [XLEN-1:0]  out_sr1,
  output logic [XLEN-1:0]  out_sr2,
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc,
  output logic [RW-1:0]    out_dest,
  input  logic             wb_load,
  input  logic [RW-1:0]    wb_dest,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             flush
);

  lc3b_control_word ctrl;
  logic [RW-1:0]    sr1_idx, sr2_idx, dest_idx;
  logic [XLEN-1:0]  rd1, rd2, imm;
  logic [XLEN-1:0]  regs [NREGS];
  logic             hazard, accept;

  control_rom u_rom (
    .op        (in_instr[15:12]),
    .long_form (in_instr[11]),
    .imm_form  (in_instr[5]),
    .ctrl      (ctrl)
  );

  assign sr1_idx  = RW'(in_instr[8:6]);
  assign sr2_idx  = ctrl.sr2_is_dest ? RW'(in_instr[11:9]) : RW'(in_instr[2:0]);
  assign dest_idx = ctrl.dest_link ? RW'(NREGS - 1) : RW'(in_instr[11:9]);

  decode_scoreboard #(.NREGS(NREGS), .MAX_PEND(MAX_PEND)) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc_en    (accept && ctrl.reg_write),
    .inc_idx   (dest_idx),
    .wb_load   (wb_load),
    .wb_dest   (wb_dest),
    .flush_dec (flush && out_valid && out_ctrl.reg_write),
    .flush_idx (out_dest),
    .src1_used (in_valid && ctrl.sr1_used),
    .src1_idx  (sr1_idx),
    .src2_used (in_valid && ctrl.sr2_used),
    .src2_idx  (sr2_idx),
    .dest_used (in_valid && ctrl.reg_write),
    .dest_idx  (dest_idx),
    .hazard    (hazard)
  );

  assign in_ready = (!out_valid || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // NOTE: the register array is reset because cleared registers are part of
  // the reset state; plain storage arrays normally skip reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (wb_load) begin
      regs[wb_dest] <= wb_data;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign rd1 = (wb_load && wb_dest == sr1_idx) ? wb_data : regs[sr1_idx];
  assign rd2 = (wb_load && wb_dest == sr2_idx) ? wb_data : regs[sr2_idx];
`else
  assign rd1 = regs[sr1_idx];
  assign rd2 = regs[sr2_idx];
`endif

  always_comb begin
    imm = '0;
    case (ctrl.imm_sel)
      IMM_ADJ6:  imm = XLEN'($signed({in_instr[5:0], 1'b0}));
      IMM_SEXT5: imm = XLEN'($signed(in_instr[4:0]));
      IMM_SEXT6: imm = XLEN'($signed(in_instr[5:0]));
      IMM_ZEXT4: imm = XLEN'(in_instr[3:0]);
      IMM_ADJ9:  imm = XLEN'($signed({in_instr[8:0], 1'b0}));
      IMM_ADJ11: imm = XLEN'($signed({in_instr[10:0], 1'b0}));
      IMM_TRAP8: imm = XLEN'({in_instr[7:0], 1'b0});
      default:   imm = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_ctrl  <= '0;
      out_sr1   <= '0;
      out_sr2   <= '0;
      out_imm   <= '0;
      out_pc    <= '0;
      out_dest  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_ctrl  <= ctrl;
      out_sr1   <= rd1;
      out_sr2   <= rd2;
      out_imm   <= imm;
      out_pc    <= in_pc;
      out_dest  <= dest_idx;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: reset, RAW stall, immediates, backpressure,
// saturation and flush, with or without DECODE_WB_BYPASS_EN.
module tb_decode_stage;
  import lc3b_types::*;

  localparam int XLEN = 16;
  localparam int RW   = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid, in_ready;
  logic [15:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid, out_ready;
  lc3b_control_word out_ctrl;
  logic [XLEN-1:0]  out_sr1, out_sr2, out_imm, out_pc;
  logic [RW-1:0]    out_dest;
  logic             wb_load;
  logic [RW-1:0]    wb_dest;
  logic [XLEN-1:0]  wb_data;
  logic             flush;

  int tests = 0;
  int fails = 0;

  decode_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_sr1   (out_sr1),
    .out_sr2   (out_sr2),
    .out_imm   (out_imm),
    .out_pc    (out_pc),
    .out_dest  (out_dest),
    .wb_load   (wb_load),
    .wb_dest   (wb_dest),
    .wb_data   (wb_data),
    .flush     (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge and leave 1 time unit for outputs to settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 16'h12A3;   // ADD R1,R2,#3
    in_pc     = 16'h3000;
    out_ready = 1'b1;
    wb_load   = 1'b0;
    wb_dest   = '0;
    wb_data   = '0;
    flush     = 1'b0;

    // Reset held two cycles with in_valid asserted.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid_low", out_valid, 0);
    rst_n = 1'b1;
    #1;
    check("rel_out_valid", out_valid, 0);
    check("rel_out_ctrl",  out_ctrl,  0);
    check("rel_out_sr1",   out_sr1,   0);
    check("rel_out_sr2",   out_sr2,   0);
    check("rel_out_imm",   out_imm,   0);
    check("rel_out_pc",    out_pc,    0);
    check("rel_out_dest",  out_dest,  0);
    check("rel_in_ready",  in_ready,  1);

    // RAW stall: ADD R1,R2,#3 then ADD R3,R1,R1.
    tick();
    check("add1_valid", out_valid, 1);
    check("add1_dest",  out_dest,  1);
    check("add1_imm",   out_imm,   16'h0003);
    check("add1_pc",    out_pc,    16'h3000);
    in_instr = 16'h1641;
    in_pc    = 16'h3002;
    #1;
    check("raw_stall_0", in_ready, 0);
    tick();
    check("raw_drained", out_valid, 0);
    check("raw_stall_1", in_ready,  0);
    wb_load = 1'b1;
    wb_dest = 3'd1;
    wb_data = 16'h0005;
    #1;
`ifdef DECODE_WB_BYPASS_EN
    check("raw_bypass_ready", in_ready, 1);
    tick();
    wb_load = 1'b0;
`else
    check("raw_wb_still_stall", in_ready, 0);
    tick();
    wb_load = 1'b0;
    #1;
    check("raw_ready_after_wb", in_ready, 1);
    tick();
`endif
    check("raw_out_valid", out_valid, 1);
    check("raw_out_sr1",   out_sr1,   16'h0005);
    check("raw_out_sr2",   out_sr2,   16'h0005);
    check("raw_out_dest",  out_dest,  3);

    // Retire R3 and drain.
    in_valid = 1'b0;
    wb_load  = 1'b1;
    wb_dest  = 3'd3;
    wb_data  = 16'h0007;
    tick();
    wb_load = 1'b0;
    check("drain_valid", out_valid, 0);

    // Immediates: TRAP x25, BR offset9=0x1FF, ADD R0,R0,#-16.
    in_valid = 1'b1;
    in_instr = 16'hF025;
    #1;
    check("trap_ready", in_ready, 1);
    tick();
    check("trap_imm",  out_imm,  16'h004A);
    check("trap_dest", out_dest, 7);
    check("trap_op",   out_ctrl.opcode, OP_TRAP);
    in_instr = 16'h0FFF;
    #1;
    check("br_ready", in_ready, 1);
    tick();
    check("br_imm", out_imm, 16'hFFFE);
    in_instr = 16'h1030;
    #1;
    check("addimm_ready", in_ready, 1);
    tick();
    check("addimm_imm", out_imm, 16'hFFF0);

    // Backpressure: ADD R2,R6,#1 held for 5 cycles.
    in_valid = 1'b0;
    tick();
    in_valid  = 1'b1;
    in_instr  = 16'h15A1;
    in_pc     = 16'h3010;
    out_ready = 1'b0;
    tick();
    in_instr = 16'h0FFF;
    in_pc    = 16'h3012;
    for (int c = 0; c < 5; c++) begin
      check("bp_valid", out_valid, 1);
      check("bp_imm",   out_imm,   16'h0001);
      check("bp_dest",  out_dest,  2);
      check("bp_pc",    out_pc,    16'h3010);
      check("bp_ready", in_ready,  0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_next_pc", out_pc, 16'h3012);

    // Saturation: four LEA R4 writers, no write-back.
    in_instr = 16'hE800;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("sat_accept", in_ready, 1);
      tick();
    end
    check("sat_stall", in_ready, 0);
    wb_load = 1'b1;
    wb_dest = 3'd4;
    wb_data = 16'h0044;
    #1;
    check("sat_stall_wb_cycle", in_ready, 0);
    tick();
    wb_load = 1'b0;
    #1;
    check("sat_released", in_ready, 1);
    tick();
    check("sat_out_dest", out_dest, 4);

    // Flush: LEA R5 then LDR R5,R6,#0 held, flush + wb R5 together.
    in_instr = 16'hEA00;
    tick();
    in_instr = 16'h6B80;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("fl_held_dest", out_dest, 5);
    check("fl_held_op",   out_ctrl.opcode, OP_LDR);
    flush   = 1'b1;
    wb_load = 1'b1;
    wb_dest = 3'd5;
    wb_data = 16'h1234;
    #1;
    check("fl_ready_low", in_ready, 0);
    tick();
    flush   = 1'b0;
    wb_load = 1'b0;
    check("fl_out_valid", out_valid, 0);
    in_valid  = 1'b1;
    in_instr  = 16'h1360;   // ADD R1,R5,#0 reads R5
    out_ready = 1'b1;
    #1;
    check("fl_r5_clear", in_ready, 1);
    tick();
    check("fl_read_valid", out_valid, 1);
    check("fl_read_sr1",   out_sr1,   16'h1234);

    // Reset mid-handshake drops the held instruction immediately.
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_sr1",   out_sr1,   0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
